// File: rtl/instr_decode_stage_if.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_if
//   Bundles the instruction-in / decoded-out handshake of the ID stage.
//   slave  : used by the decode stage (consumes instr_in, produces decode)
//   master : used by whoever feeds instructions and consumes decode results
//   Signals
//     flush      branch redirect, drops all buffered instructions
//     in_valid / in_ready / instr_in          upstream handshake + word
//     out_valid / out_ready                   downstream handshake
//     opcode, rd, rs1, rs2                    register / opcode fields
//     selectSize, imm16..imm12, imm_used      immediate selection for extender
//     illegal, ill_count                      undefined class flag + counter
// ---------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int ILL_CNT_W = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           opcode;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [2:0]           selectSize;
  logic [15:0]          imm16;
  logic [20:0]          imm21;
  logic [8:0]           imm9;
  logic [17:0]          imm18;
  logic [11:0]          imm12;
  logic                 imm_used;
  logic                 illegal;
  logic [ILL_CNT_W-1:0] ill_count;

  modport slave (
    input  flush, in_valid, instr_in, out_ready,
    output in_ready, out_valid, opcode, rd, rs1, rs2, selectSize,
           imm16, imm21, imm9, imm18, imm12, imm_used, illegal, ill_count
  );

  modport master (
    output flush, in_valid, instr_in, out_ready,
    input  in_ready, out_valid, opcode, rd, rs1, rs2, selectSize,
           imm16, imm21, imm9, imm18, imm12, imm_used, illegal, ill_count
  );
endinterface

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//   Instruction-decode stage feeding the immediate extender. Accepts 32-bit
//   words over valid/ready, classifies them on opcode[5:3], slices register
//   fields and immediate candidates, and holds results in a 2-entry skid
//   buffer (main register drives the outputs, skid absorbs one word of
//   backpressure). Counts accepted illegal words, saturating.
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    instr_decode_stage_if.slave (handshakes, flush, decoded fields)
// ---------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instr_decode_stage_if.slave      bus
);

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  sel;
    logic        imm_used;
    logic        illegal;
  } entry_t;

  // Class decode on opcode[5:3] == instr[31:29].
  function automatic entry_t decode(input logic [31:0] w);
    entry_t e;
    e.word     = w;
    e.sel      = 3'd0;
    e.imm_used = 1'b1;
    e.illegal  = 1'b0;
    case (w[31:29])
      3'b000:  e.imm_used = 1'b0;
      3'b001:  e.sel = 3'd0;
      3'b010:  e.sel = 3'd1;
      3'b011:  e.sel = 3'd2;
      3'b100:  e.sel = 3'd3;
      3'b101:  e.sel = 3'd4;
      default: begin
        e.imm_used = 1'b0;
        e.illegal  = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  entry_t               main_q, main_d;
  entry_t               skid_q, skid_d;
  logic                 main_valid_q, main_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  entry_t new_entry;
  logic   accept;

  always_comb begin
    new_entry    = decode(bus.instr_in);
    // in_ready is the registered complement of skid occupancy.
    accept       = bus.in_valid & ~skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    ill_cnt_d    = ill_cnt_q;

    if (bus.flush) begin
      // Redirect: everything buffered or offered this cycle is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && new_entry.illegal)
        ill_cnt_d = sat_inc(ill_cnt_q);

      if (!main_valid_q) begin
        if (accept) begin
          main_d       = new_entry;
          main_valid_d = 1'b1;
        end
      end else if (bus.out_ready) begin
        if (skid_valid_q) begin
          // No accept is possible here because in_ready is low.
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d = new_entry;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ill_cnt_q    <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign bus.in_ready   = ~skid_valid_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.opcode     = main_q.word[31:26];
  assign bus.rd         = main_q.word[25:21];
  assign bus.rs1        = main_q.word[20:16];
  assign bus.rs2        = main_q.word[15:11];
  assign bus.selectSize = main_q.sel;
  assign bus.imm16      = main_q.word[15:0];
  assign bus.imm21      = main_q.word[20:0];
  assign bus.imm9       = main_q.word[8:0];
  assign bus.imm18      = main_q.word[17:0];
  assign bus.imm12      = main_q.word[11:0];
  assign bus.imm_used   = main_q.imm_used;
  assign bus.illegal    = main_q.illegal;
  assign bus.ill_count  = ill_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//   Directed bench for instr_decode_stage: reset, decode fields, backpressure
//   through the skid entry, class sweep, flush, counter saturation and reset
//   in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_ill;

  instr_decode_stage_if #(.ILL_CNT_W(8)) bus ();

  instr_decode_stage #(.ILL_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'hC000_0000;
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    n_checks += 5;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    if (bus.ill_count !== 8'd0) begin n_fail++; $display("FAIL reset_ill_count got %0d exp 0", bus.ill_count); end
    if (bus.selectSize !== 3'd0) begin n_fail++; $display("FAIL reset_selectSize got %0d exp 0", bus.selectSize); end
    if (bus.opcode !== 6'd0) begin n_fail++; $display("FAIL reset_opcode got %h exp 00", bus.opcode); end
    exp_ill = 0;
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'h2C22_0010;
    tick();
    bus.in_valid = 1'b0;
    n_checks += 8;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_out_valid got %b exp 1", bus.out_valid); end
    if (bus.opcode !== 6'h0B) begin n_fail++; $display("FAIL dec_opcode got %h exp 0b", bus.opcode); end
    if (bus.selectSize !== 3'd0) begin n_fail++; $display("FAIL dec_sel got %0d exp 0", bus.selectSize); end
    if (bus.rd !== 5'd1) begin n_fail++; $display("FAIL dec_rd got %0d exp 1", bus.rd); end
    if (bus.rs1 !== 5'd2) begin n_fail++; $display("FAIL dec_rs1 got %0d exp 2", bus.rs1); end
    if (bus.imm16 !== 16'h0010) begin n_fail++; $display("FAIL dec_imm16 got %h exp 0010", bus.imm16); end
    if (bus.imm_used !== 1'b1) begin n_fail++; $display("FAIL dec_imm_used got %b exp 1", bus.imm_used); end
    if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL dec_illegal got %b exp 0", bus.illegal); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    // A: opcode 0x08 rd 3 rs1 4 ; B: opcode 0x10 rd 5 rs1 6 (class 010)
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'h2064_1111;
    tick();
    n_checks += 3;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_a_valid got %b exp 1", bus.out_valid); end
    if (bus.rd !== 5'd3) begin n_fail++; $display("FAIL bp_a_rd got %0d exp 3", bus.rd); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_a_in_ready got %b exp 1", bus.in_ready); end
    bus.instr_in = 32'h40A6_2222;
    tick();
    bus.in_valid = 1'b0;
    n_checks += 3;
    if (bus.rd !== 5'd3) begin n_fail++; $display("FAIL bp_hold_rd got %0d exp 3", bus.rd); end
    if (bus.imm16 !== 16'h1111) begin n_fail++; $display("FAIL bp_hold_imm16 got %h exp 1111", bus.imm16); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b exp 0", bus.in_ready); end
    tick();
    n_checks += 2;
    if (bus.rd !== 5'd3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold2 got rd=%0d v=%b exp rd=3 v=1", bus.rd, bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold2_in_ready got %b exp 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    tick();
    n_checks += 4;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b_valid got %b exp 1", bus.out_valid); end
    if (bus.rd !== 5'd5) begin n_fail++; $display("FAIL bp_b_rd got %0d exp 5", bus.rd); end
    if (bus.selectSize !== 3'd1) begin n_fail++; $display("FAIL bp_b_sel got %0d exp 1", bus.selectSize); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b_in_ready got %b exp 1", bus.in_ready); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_class_sweep();
    logic [31:0] vin  [7];
    logic [2:0]  vsel [7];
    logic        vimm [7];
    logic        vill [7];
    vin[0] = 32'h4123_4567; vsel[0] = 3'd1; vimm[0] = 1'b1; vill[0] = 1'b0;
    vin[1] = 32'h6000_0000; vsel[1] = 3'd2; vimm[1] = 1'b1; vill[1] = 1'b0;
    vin[2] = 32'h8000_0000; vsel[2] = 3'd3; vimm[2] = 1'b1; vill[2] = 1'b0;
    vin[3] = 32'hA000_0000; vsel[3] = 3'd4; vimm[3] = 1'b1; vill[3] = 1'b0;
    vin[4] = 32'hC000_0000; vsel[4] = 3'd0; vimm[4] = 1'b0; vill[4] = 1'b1;
    vin[5] = 32'hE000_0000; vsel[5] = 3'd0; vimm[5] = 1'b0; vill[5] = 1'b1;
    vin[6] = 32'h0000_0000; vsel[6] = 3'd0; vimm[6] = 1'b0; vill[6] = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.instr_in = vin[i];
      if (vill[i]) exp_ill++;
      tick();
      n_checks += 5;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_valid got %b exp 1", i, bus.out_valid); end
      if (bus.selectSize !== vsel[i]) begin n_fail++; $display("FAIL sweep%0d_sel got %0d exp %0d", i, bus.selectSize, vsel[i]); end
      if (bus.imm_used !== vimm[i]) begin n_fail++; $display("FAIL sweep%0d_imm_used got %b exp %b", i, bus.imm_used, vimm[i]); end
      if (bus.illegal !== vill[i]) begin n_fail++; $display("FAIL sweep%0d_illegal got %b exp %b", i, bus.illegal, vill[i]); end
      if (bus.ill_count !== exp_ill[7:0]) begin n_fail++; $display("FAIL sweep%0d_ill_count got %0d exp %0d", i, bus.ill_count, exp_ill); end
      if (i == 0) begin
        n_checks += 8;
        if (bus.rd !== 5'd9) begin n_fail++; $display("FAIL slice_rd got %0d exp 9", bus.rd); end
        if (bus.rs1 !== 5'd3) begin n_fail++; $display("FAIL slice_rs1 got %0d exp 3", bus.rs1); end
        if (bus.rs2 !== 5'd8) begin n_fail++; $display("FAIL slice_rs2 got %0d exp 8", bus.rs2); end
        if (bus.imm16 !== 16'h4567) begin n_fail++; $display("FAIL slice_imm16 got %h exp 4567", bus.imm16); end
        if (bus.imm21 !== 21'h03_4567) begin n_fail++; $display("FAIL slice_imm21 got %h exp 034567", bus.imm21); end
        if (bus.imm9 !== 9'h167) begin n_fail++; $display("FAIL slice_imm9 got %h exp 167", bus.imm9); end
        if (bus.imm18 !== 18'h3_4567) begin n_fail++; $display("FAIL slice_imm18 got %h exp 34567", bus.imm18); end
        if (bus.imm12 !== 12'h567) begin n_fail++; $display("FAIL slice_imm12 got %h exp 567", bus.imm12); end
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'h2064_1111;
    tick();
    bus.instr_in = 32'h40A6_2222;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b exp 0", bus.in_ready); end
    bus.flush    = 1'b1;
    bus.instr_in = 32'h2000_0077;
    tick();
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    // Flush still high with in_ready=1: an offered illegal word is dropped, not counted.
    bus.instr_in = 32'hC000_0000;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost got %b exp 0", bus.out_valid); end
    if (bus.ill_count !== exp_ill[7:0]) begin n_fail++; $display("FAIL flush_ill_count got %0d exp %0d", bus.ill_count, exp_ill); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'hA1E0_0042;
    tick();
    bus.in_valid = 1'b0;
    n_checks += 2;
    if (bus.out_valid !== 1'b1 || bus.opcode !== 6'h28) begin n_fail++; $display("FAIL flush_resume got v=%b op=%h exp v=1 op=28", bus.out_valid, bus.opcode); end
    if (bus.selectSize !== 3'd4) begin n_fail++; $display("FAIL flush_resume_sel got %0d exp 4", bus.selectSize); end
    tick();
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'hC000_0000;
    // exp_ill is 2 here; 253 more reach 255 exactly.
    for (int i = 0; i < 253; i++) tick();
    n_checks++;
    if (bus.ill_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d exp 255", bus.ill_count); end
    for (int i = 0; i < 47; i++) tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.ill_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d exp 255", bus.ill_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr_in  = 32'h2064_1111;
    tick();
    bus.instr_in = 32'h40A6_2222;
    rst_n        = 1'b0;
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
    if (bus.ill_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_ill_count got %0d exp 0", bus.ill_count); end
    if (bus.rd !== 5'd0 || bus.imm16 !== 16'd0) begin n_fail++; $display("FAIL rstmid_data got rd=%0d imm16=%h exp 0", bus.rd, bus.imm16); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_b got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_ill       = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr_in  = 32'd0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_decode();
    test_backpressure();
    test_class_sweep();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
